// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the push-button conditioning path.
//   - state_t          : 2-bit debounce FSM encoding
//   - DEFAULT_DEBOUNCE_CYCLES / DEFAULT_CNT_W : 10 ms at 50 MHz
// -----------------------------------------------------------------------------
package debounce_pkg;

   // Encoding is fixed so that bit 1 equals the accepted level and bit 0
   // marks a qualification window in progress.
   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int DEFAULT_CNT_W           = 19;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   1-bit two-flop synchroniser for a level that is asynchronous to clk.
//   Ports:
//     clk   : destination clock
//     reset : synchronous, active-high; clears both flops
//     d     : asynchronous input level
//     q     : synchronised level, two clk edges behind d
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1_reg;
   logic s2_reg;

   // First flop may go metastable; the second gives it a full period to
   // resolve before anything downstream looks at it.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
      end else begin
         s1_reg <= d;
         s2_reg <= s1_reg;
      end
   end

   assign q = s2_reg;

endmodule : sync_2ff

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   Synchronises a raw bouncing push-button level and filters it with a
//   stability counter. A new level is accepted only after the synchronised
//   input has held it for DEBOUNCE_CYCLES consecutive cycles.
//   Parameters:
//     DEBOUNCE_CYCLES : qualification length in clk cycles (>= 2)
//     CNT_W           : stability counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//   Ports:
//     clk        : single clock, rising edge
//     reset      : synchronous, active-high
//     btn_in     : raw button level, asynchronous to clk
//     level      : debounced level (registered)
//     rise_pulse : one-cycle pulse on accepted 0->1 (registered)
//     fall_pulse : one-cycle pulse on accepted 1->0 (registered)
// -----------------------------------------------------------------------------
module button_debounce
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic level,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s2;
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             level_reg;
   logic             rise_reg;
   logic             fall_reg;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (s2)
   );

   // The cycle that moves IDLE_* -> WAIT_* already counts as the first stable
   // sample, so the counter is loaded with 1 there and acceptance happens when
   // it reads DEBOUNCE_CYCLES-1 with the input still stable. That gives a
   // total of DEBOUNCE_CYCLES stable samples and keeps cnt below
   // DEBOUNCE_CYCLES, so it can never wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE_LOW;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;

         case (state_reg)
            IDLE_LOW: begin
               if (s2) begin
                  state_reg <= WAIT_HIGH;
                  cnt_reg   <= CNT_ONE;
               end
            end

            WAIT_HIGH: begin
               if (!s2) begin
                  // Bounce: drop the attempt silently.
                  state_reg <= IDLE_LOW;
                  cnt_reg   <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= IDLE_HIGH;
                  cnt_reg   <= '0;
                  level_reg <= 1'b1;
                  rise_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end

            IDLE_HIGH: begin
               if (!s2) begin
                  state_reg <= WAIT_LOW;
                  cnt_reg   <= CNT_ONE;
               end
            end

            WAIT_LOW: begin
               if (s2) begin
                  state_reg <= IDLE_HIGH;
                  cnt_reg   <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= IDLE_LOW;
                  cnt_reg   <= '0;
                  level_reg <= 1'b0;
                  fall_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end

            default: begin
               state_reg <= IDLE_LOW;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   assign level      = level_reg;
   assign rise_pulse = rise_reg;
   assign fall_pulse = fall_reg;

endmodule : button_debounce

// File: doc/button_debounce.md
# button_debounce

Input conditioning stage that sits directly upstream of the 4-bit `counter`. It synchronises a raw, asynchronous, bouncing push-button level into `clk` and filters it with a stability counter. It outputs a clean debounced level, plus single-cycle rise and fall pulses. `rise_pulse` is the event that advances the downstream counter, one count per physical press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive synchronised cycles the input must hold a new value before it is accepted. Must be ≥ 2. Benches override it to 4.
- `CNT_W`, default 19: stability counter width. Must satisfy 2^CNT_W ≥ `DEBOUNCE_CYCLES`.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `btn_in` input 1: raw button level, asynchronous to `clk`.
- `level` output 1: debounced button level.
- `rise_pulse` output 1: one-cycle pulse when `level` goes 0→1.
- `fall_pulse` output 1: one-cycle pulse when `level` goes 1→0.

## Operation
- **Synchroniser.** Two-flop chain `btn_in` → `s1` → `s2`. The FSM sees `s2` only.
- **FSM states.** `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`. The state register, `cnt`, and all outputs are registered.
- **`IDLE_LOW`**
  - `s2`=1: go to `WAIT_HIGH`, `cnt`←1.
  - Otherwise hold.
- **`WAIT_HIGH`**
  - `s2`=0: return to `IDLE_LOW`, `cnt`←0. Bounce aborts the attempt and no pulse is issued.
  - `s2`=1 and `cnt`==`DEBOUNCE_CYCLES`−1: go to `IDLE_HIGH`, `level`←1, `rise_pulse`←1, `cnt`←0.
  - `s2`=1, otherwise: `cnt`←`cnt`+1.
- **`IDLE_HIGH` / `WAIT_LOW`.** Mirror of the above with the polarity inverted. The accepted transition sets `level`←0 and `fall_pulse`←1.
- **Pulses.** `rise_pulse` and `fall_pulse` default to 0 every cycle. They are never both 1 in the same cycle.
- **Counter range.** `cnt` never exceeds `DEBOUNCE_CYCLES`−1 and never wraps.
- **Reset** (any cycle, including mid-`WAIT_*`):
  - `s1`, `s2`, `cnt` ← 0; state ← `IDLE_LOW`.
  - `level`, `rise_pulse`, `fall_pulse` ← 0.
  - A pulse due on that edge is suppressed.
- **Button held high through reset release.** The block re-qualifies the input from `IDLE_LOW` and issues one `rise_pulse` after the full latency.

## Timing
- **Rise latency.** Let `btn_in` settle high before edge k and stay high. Then:
  - `s1`=1 after edge k and `s2`=1 after edge k+1.
  - `WAIT_HIGH` is entered at edge k+2.
  - `level`/`rise_pulse` assert at edge k+`DEBOUNCE_CYCLES`+1. With N=4, that is edge k+5.
- **Fall latency.** Identical, with `fall_pulse`.
- **Pulse width.** Exactly one `clk` period.
- **`level` width.** Holds for at least `DEBOUNCE_CYCLES` cycles between changes.
- **Glitch rejection.** A glitch on `s2` shorter than `DEBOUNCE_CYCLES` cycles produces no output change. The next stable run restarts counting from 1.
- **Combinational paths.** None from `btn_in` to any output.

## Structure
- **Shared package `debounce_pkg`.**
  - 2-bit state encoding localparams: `IDLE_LOW`=0, `WAIT_HIGH`=1, `IDLE_HIGH`=2, `WAIT_LOW`=3.
  - Default `DEBOUNCE_CYCLES` / `CNT_W` constants.
- **Sub-module `sync_2ff`.** 1-bit two-flop synchroniser with `clk`, synchronous active-high `reset`, `d`, `q`. It is reused for other asynchronous inputs.
- **Top level.** `button_debounce` instantiates `sync_2ff` and contains the FSM and `cnt`. The top-level integration ties `rise_pulse` to the counter's advance input.

## Test plan
All scenarios use N=4 and a 100 ns `clk`, with `reset`=1 for edges 0–1.

1. **Reset values.** `reset` high with `btn_in`=1 → `level`=0, pulses 0, state `IDLE_LOW` throughout reset.
2. **Clean press.** Reset released at edge 2; `btn_in` 0→1 before edge 5, held → `rise_pulse`=1 exactly after edge 10 (k+5 with k=5); `level`=1 from edge 10 on; no second pulse.
3. **Bounce rejection.** `btn_in` toggles 1,0,1,0 every cycle for 8 cycles, then holds 1 → zero pulses during the toggling; one `rise_pulse` at 5 edges after the first edge of the final stable run.
4. **Release.** From `level`=1, `btn_in`→0 held → `fall_pulse` one cycle at k+5; `level`=0; `rise_pulse` stays 0.
5. **Reset mid-`WAIT_HIGH`.** Assert `reset` one edge before the expected `rise_pulse` → no pulse; `level`=0; after release with `btn_in` still 1 → `rise_pulse` at 5 edges after the first post-reset sampling edge.
6. **Integration with `counter`.** Five clean presses (each held 10 cycles, released 10 cycles) → counter `out` = 4'd5; `out` wraps to 0 after 16 presses.
